alu_issue_stage: RTL

- Drives the ALU: decodes RV32I instruction fields into the 4-bit ALU op, selects operands, and presents them from a registered decode stage (D).
- Captures the ALU result and flag into an execute/writeback register (E).
- Resolves conditional branches and issues a redirect with target.
- Two-entry pipeline with valid/ready handshake on both sides; the ALU itself stays combinational and external.

---
 rtl/alu_issue_stage_pkg.sv | 82 ++++++++
 rtl/alu_issue_stage_lca.sv | 35 +++
 rtl/alu_issue_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - shared ALU op codes, RV32I opcodes and issue decode
package alu_issue_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_BEQ  = 4'b1000;
  localparam logic [3:0] ALU_BNE  = 4'b1100;
  localparam logic [3:0] ALU_BLT  = 4'b1010;
  localparam logic [3:0] ALU_BGE  = 4'b1110;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {SRC_A_RS1, SRC_A_ZERO, SRC_A_PC} a_sel_e;
  typedef enum logic [1:0] {BR_NONE, BR_FLAG, BR_LTU, BR_GEU} br_kind_e;

  typedef struct packed {
    logic [3:0] op;
    a_sel_e     a_sel;
    logic       b_imm;
    logic       shamt;
    br_kind_e   br;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] opcode, input logic [2:0] funct3,
                                  input logic funct7b5);
    dec_t d;
    d.op      = ALU_ADD;
    d.a_sel   = SRC_A_RS1;
    d.b_imm   = 1'b1;
    d.shamt   = 1'b0;
    d.br      = BR_NONE;
    d.illegal = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        d.b_imm = (opcode == OPC_OP_IMM);
        case (funct3)
          3'b000: d.op = (opcode == OPC_OP && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: begin d.op = ALU_SLL; d.shamt = 1'b1; end
          3'b010: d.op = ALU_SLT;
          3'b011: d.op = ALU_SLTU;
          3'b100: d.op = ALU_XOR;
          3'b101: begin d.op = funct7b5 ? ALU_SRA : ALU_SRL; d.shamt = 1'b1; end
          3'b110: d.op = ALU_OR;
          default: d.op = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        d.b_imm = 1'b0;
        case (funct3)
          3'b000: begin d.op = ALU_BEQ;  d.br = BR_FLAG; end
          3'b001: begin d.op = ALU_BNE;  d.br = BR_FLAG; end
          3'b100: begin d.op = ALU_BLT;  d.br = BR_FLAG; end
          3'b101: begin d.op = ALU_BGE;  d.br = BR_FLAG; end
          3'b110: begin d.op = ALU_SLTU; d.br = BR_LTU;  end
          3'b111: begin d.op = ALU_SLTU; d.br = BR_GEU;  end
          default: d.illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: ;
      OPC_LUI:   d.a_sel = SRC_A_ZERO;
      OPC_AUIPC: d.a_sel = SRC_A_PC;
      default:   d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_stage_lca.sv
// rtl/alu_issue_stage_lca.sv - lookahead-carry adder, 4-bit groups chained by group carry
module alu_issue_stage_lca #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic             cin;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c   = '0;
    cin = 1'b0;
    for (int k = 0; k < WIDTH / 4; k++) begin
      c[4*k]   = cin;
      c[4*k+1] = g[4*k] | (p[4*k] & cin);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cin);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cin);
      cin      = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & cin);
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decode (D) and execute/writeback (E) registers around an external ALU
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iValid,
  output logic            oReady,
  input  logic [6:0]      iOpcode,
  input  logic [2:0]      iFunct3,
  input  logic            iFunct7b5,
  input  logic [XLEN-1:0] iRs1Data,
  input  logic [XLEN-1:0] iRs2Data,
  input  logic [XLEN-1:0] iImm,
  input  logic [XLEN-1:0] iPc,
  output logic [XLEN-1:0] oAluA,
  output logic [XLEN-1:0] oAluB,
  output logic [3:0]      oAluOp,
  input  logic [XLEN-1:0] iAluData,
  input  logic            iAluZero,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oResult,
  output logic            oIllegal,
  output logic            oRedirect,
  output logic [XLEN-1:0] oTarget
);

  dec_t            dec;
  logic [XLEN-1:0] a_next;
  logic [XLEN-1:0] b_next;
  logic [XLEN-1:0] target_next;

  logic            d_valid;
  logic            d_illegal;
  br_kind_e        d_br;
  logic [XLEN-1:0] d_target;
  logic            e_valid;

  logic            adv_e;
  logic            d_load;
  logic            e_load;
  logic            taken;
  logic            flush;

  alu_issue_stage_lca #(.WIDTH(XLEN)) u_target_add (
    .a   (iPc),
    .b   (iImm),
    .sum (target_next)
  );

  always_comb begin
    dec = decode(iOpcode, iFunct3, iFunct7b5);
    case (dec.a_sel)
      SRC_A_ZERO: a_next = '0;
      SRC_A_PC:   a_next = iPc;
      default:    a_next = iRs1Data;
    endcase
    b_next = dec.b_imm ? iImm : iRs2Data;
    // Shift amounts only use 5 bits; SRAI's funct7 sits in imm[11:5]
    if (dec.shamt) b_next = {{(XLEN-5){1'b0}}, b_next[4:0]};
  end

  always_comb begin
    case (d_br)
      BR_FLAG: taken = iAluZero;
      BR_LTU:  taken = iAluData[0];
      BR_GEU:  taken = ~iAluData[0];
      default: taken = 1'b0;
    endcase
  end

  assign adv_e  = !e_valid || iReady;
  assign oReady = !d_valid || adv_e;
  assign d_load = iValid && oReady;
  assign e_load = d_valid && adv_e;
  assign flush  = e_load && taken && !d_illegal;
  assign oValid = e_valid;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      d_valid   <= 1'b0;
      oAluA     <= '0;
      oAluB     <= '0;
      oAluOp    <= ALU_ADD;
      d_br      <= BR_NONE;
      d_illegal <= 1'b0;
      d_target  <= '0;
      e_valid   <= 1'b0;
      oResult   <= '0;
      oIllegal  <= 1'b0;
      oRedirect <= 1'b0;
      oTarget   <= '0;
    end else begin
      // A taken branch leaving D squashes whatever is accepted on the same edge
      if (d_load && !flush) begin
        d_valid   <= 1'b1;
        oAluA     <= a_next;
        oAluB     <= b_next;
        oAluOp    <= dec.op;
        d_br      <= dec.br;
        d_illegal <= dec.illegal;
        d_target  <= target_next;
      end else if (e_load) begin
        d_valid <= 1'b0;
      end

      if (e_load) begin
        e_valid  <= 1'b1;
        oResult  <= iAluData;
        oIllegal <= d_illegal;
      end else if (iReady) begin
        e_valid  <= 1'b0;
        oIllegal <= 1'b0;
      end

      oRedirect <= flush;
      if (flush) oTarget <= d_target;
    end
  end

endmodule
